id_ex_pipe_reg: RTL and testbench
=================================

// Module: id_ex_pipe_reg
// PURPOSE
// - Decode-to-execute pipeline register for the RV32I 5-stage core; captures controlUnitTop outputs plus decoded operands each cycle.
// - Detects load-use hazards against the instruction in EX; stalls fetch/decode and inserts a bubble.
// - Applies branch-taken flush from EX; counts inserted bubbles for performance visibility.
// PARAMETERS
// - XLEN        32  datapath width (pc, operands, immediate)
// - REGW        5   register-index width
// - CNTW        16  width of the saturating bubble counter
// PORTS
// - clk          in   1     clock, all state on rising edge
// - rst          in   1     reset, synchronous, active-high
// - validD       in   1     decode-stage instruction is real (0 = bubble from IF/ID)
// - pcD          in   XLEN  PC of decode instruction
// - pcPlus4D     in   XLEN  PC+4 of decode instruction
// - rd1D, rd2D   in   XLEN  register-file read data
// - immExtD      in   XLEN  sign-extended immediate
// - rs1D, rs2D   in   REGW  source register indices
// - rdD          in   REGW  destination register index
// - regWriteD, aluSrcD, memWriteD, resultSrcD, branchD  in 1  control from controlUnitTop
// - aluControlD  in   3     ALU operation from controlUnitTop
// - flushE       in   1     branch taken in EX; kill instruction entering EX
// - validE       out  1     EX-stage instruction is real
// - pcE, pcPlus4E, rd1E, rd2E, immExtE  out XLEN  registered copies
// - rs1E, rs2E, rdE  out REGW  registered copies
// - regWriteE, aluSrcE, memWriteE, resultSrcE, branchE  out 1  registered control
// - aluControlE  out  3     registered ALU operation
// - stallF, stallD  out 1   hold PC and IF/ID register (combinational)
// - bubbleCount  out  CNTW  number of bubbles inserted (load-use + flush)
// BEHAVIOUR
// - Reset: every registered output 0 (validE=0, all control 0, data 0, indices 0, bubbleCount=0); stallF=stallD=0 when rst=1.
// - loadUse (comb) = validE & resultSrcE & regWriteE & (rdE!=0) & validD & ((rdE==rs1D)|(rdE==rs2D)).
// - stallF = stallD = loadUse & ~flushE & ~rst.
// - Per-edge priority: rst > flushE > loadUse > capture.
//   - flushE: load bubble (validE=0, regWriteE=memWriteE=branchE=0, resultSrcE=aluSrcE=0, aluControlE=0); data fields don't-care but held at 0.
//   - loadUse: load bubble as above; D-stage contents are retained upstream via stallD, re-presented next cycle.
//   - capture: all E outputs <= D inputs; validE <= validD; if validD=0, control fields forced 0.
// - A bubble never writes the register file or memory and never branches: control gating is mandatory, not relying on validE downstream.
// - bubbleCount increments by 1 on each edge where a bubble is loaded due to flushE or loadUse with validD=1; saturates at all-ones; cleared only by rst.
// - Latency: exactly 1 cycle D->E; load-use costs exactly 1 bubble (loaded instr moves to MEM, dependent re-evaluated, no second stall).
// - rd=x0 never triggers a stall; rs2 compared unconditionally (conservative stall on I-type accepted).
// - Simultaneous flushE & loadUse: flush wins, no stall asserted (D instruction is wrong-path).
// - rst mid-stall: next cycle validE=0, stalls deasserted, counter 0.
// STRUCTURE
// - Shared package core_pkg: XLEN, REGW, ctrl_t struct {regWrite, aluSrc, memWrite, resultSrc, branch, aluControl[2:0]}, CTRL_NOP constant.
// - One sub-module: load_use_detect (pure comb, produces loadUse); register bank and counter stay in this module.
// TESTING
// - Reset: rst=1 two cycles with random D inputs -> all outputs 0, stallF=stallD=0, bubbleCount=0.
// - Pass-through: validD=1, pcD=0x100, aluControlD=3'b010, regWriteD=1, rdD=5 -> next cycle pcE=0x100, aluControlE=2, regWriteE=1, rdE=5, validE=1.
// - Load-use: E holds lw x5 (resultSrcE=1, regWriteE=1, rdE=5), D has add rs1D=5 -> stallF=stallD=1, next cycle validE=0, regWriteE=0, bubbleCount=1; following cycle add captured, no stall.
// - x0 load: lw x0 in E, D rs1D=0 -> no stall, direct capture.
// - Flush priority: flushE=1 with loadUse true -> stallF=stallD=0, next validE=0, memWriteE=0, bubbleCount+1.
// - Saturation: CNTW=4, force 20 flush cycles -> bubbleCount stays 4'hF; rst -> 0.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared widths and control bundle for the RV32I core pipeline
package core_pkg;

    localparam int XLEN = 32;
    localparam int REGW = 5;
    localparam int CNTW = 16;

    typedef struct packed {
        logic       regWrite;
        logic       aluSrc;
        logic       memWrite;
        logic       resultSrc;
        logic       branch;
        logic [2:0] aluControl;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{default: '0};

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// rtl/id_ex_pipe_reg_if.sv - decode-stage inputs, execute-stage outputs and stall lines of the ID/EX register
interface id_ex_pipe_reg_if
    import core_pkg::*;
#(
    parameter int CW = CNTW
);
    logic            validD;
    logic [XLEN-1:0] pcD, pcPlus4D, rd1D, rd2D, immExtD;
    logic [REGW-1:0] rs1D, rs2D, rdD;
    logic            regWriteD, aluSrcD, memWriteD, resultSrcD, branchD;
    logic [2:0]      aluControlD;
    logic            flushE;

    logic            validE;
    logic [XLEN-1:0] pcE, pcPlus4E, rd1E, rd2E, immExtE;
    logic [REGW-1:0] rs1E, rs2E, rdE;
    logic            regWriteE, aluSrcE, memWriteE, resultSrcE, branchE;
    logic [2:0]      aluControlE;
    logic            stallF, stallD;
    logic [CW-1:0]   bubbleCount;

    modport master (
        output validD, pcD, pcPlus4D, rd1D, rd2D, immExtD, rs1D, rs2D, rdD,
               regWriteD, aluSrcD, memWriteD, resultSrcD, branchD, aluControlD, flushE,
        input  validE, pcE, pcPlus4E, rd1E, rd2E, immExtE, rs1E, rs2E, rdE,
               regWriteE, aluSrcE, memWriteE, resultSrcE, branchE, aluControlE,
               stallF, stallD, bubbleCount
    );

    modport slave (
        input  validD, pcD, pcPlus4D, rd1D, rd2D, immExtD, rs1D, rs2D, rdD,
               regWriteD, aluSrcD, memWriteD, resultSrcD, branchD, aluControlD, flushE,
        output validE, pcE, pcPlus4E, rd1E, rd2E, immExtE, rs1E, rs2E, rdE,
               regWriteE, aluSrcE, memWriteE, resultSrcE, branchE, aluControlE,
               stallF, stallD, bubbleCount
    );
endinterface

// File: rtl/id_ex_pipe_reg_load_use_detect.sv
// rtl/id_ex_pipe_reg_load_use_detect.sv - flags a decode instruction reading the register a load in EX will write
module load_use_detect
    import core_pkg::*;
(
    input  logic            validE,
    input  logic            resultSrcE,
    input  logic            regWriteE,
    input  logic [REGW-1:0] rdE,
    input  logic            validD,
    input  logic [REGW-1:0] rs1D,
    input  logic [REGW-1:0] rs2D,
    output logic            loadUse
);
    // rs2 is compared even for I-type; an occasional needless stall is cheaper than decoding format here
    assign loadUse = validE & resultSrcE & regWriteE & (rdE != '0) & validD
                   & ((rdE == rs1D) | (rdE == rs2D));
endmodule

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with load-use stall, branch flush and bubble counter
module id_ex_pipe_reg
    import core_pkg::*;
#(
    parameter int CW = CNTW
)(
    input  logic                 clk,
    input  logic                 rst,
    id_ex_pipe_reg_if.slave      bus
);
    logic    load_use;
    logic    bubble;
    ctrl_t   ctrl_d;
    ctrl_t   ctrl_q;
    logic [CW-1:0] bubble_cnt;

    load_use_detect u_load_use_detect (
        .validE     (bus.validE),
        .resultSrcE (bus.resultSrcE),
        .regWriteE  (bus.regWriteE),
        .rdE        (bus.rdE),
        .validD     (bus.validD),
        .rs1D       (bus.rs1D),
        .rs2D       (bus.rs2D),
        .loadUse    (load_use)
    );

    // A wrong-path decode instruction must not hold up fetch, so flush masks the stall
    assign bus.stallF = load_use & ~bus.flushE & ~rst;
    assign bus.stallD = load_use & ~bus.flushE & ~rst;
    assign bubble     = bus.flushE | load_use;

    always_comb begin
        ctrl_d = CTRL_NOP;
        if (bus.validD) begin
            ctrl_d = '{regWrite:   bus.regWriteD,
                       aluSrc:     bus.aluSrcD,
                       memWrite:   bus.memWriteD,
                       resultSrc:  bus.resultSrcD,
                       branch:     bus.branchD,
                       aluControl: bus.aluControlD};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            bus.validE   <= 1'b0;
            ctrl_q       <= CTRL_NOP;
            bus.pcE      <= '0;
            bus.pcPlus4E <= '0;
            bus.rd1E     <= '0;
            bus.rd2E     <= '0;
            bus.immExtE  <= '0;
            bus.rs1E     <= '0;
            bus.rs2E     <= '0;
            bus.rdE      <= '0;
        end else begin
            bus.validE   <= bus.validD;
            ctrl_q       <= ctrl_d;
            bus.pcE      <= bus.pcD;
            bus.pcPlus4E <= bus.pcPlus4D;
            bus.rd1E     <= bus.rd1D;
            bus.rd2E     <= bus.rd2D;
            bus.immExtE  <= bus.immExtD;
            bus.rs1E     <= bus.rs1D;
            bus.rs2E     <= bus.rs2D;
            bus.rdE      <= bus.rdD;
        end
    end

    // Only bubbles that displace a real decode instruction are counted
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (bubble && bus.validD && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

    assign bus.regWriteE   = ctrl_q.regWrite;
    assign bus.aluSrcE     = ctrl_q.aluSrc;
    assign bus.memWriteE   = ctrl_q.memWrite;
    assign bus.resultSrcE  = ctrl_q.resultSrc;
    assign bus.branchE     = ctrl_q.branch;
    assign bus.aluControlE = ctrl_q.aluControl;
    assign bus.bubbleCount = bubble_cnt;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - directed checks of the ID/EX register at counter widths 16 and 4
module tb_id_ex_pipe_reg;
    import core_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg_if #(.CW(16)) bus ();
    id_ex_pipe_reg_if #(.CW(4))  bus4 ();

    id_ex_pipe_reg #(.CW(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
    id_ex_pipe_reg #(.CW(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

    assign bus4.validD      = bus.validD;
    assign bus4.pcD         = bus.pcD;
    assign bus4.pcPlus4D    = bus.pcPlus4D;
    assign bus4.rd1D        = bus.rd1D;
    assign bus4.rd2D        = bus.rd2D;
    assign bus4.immExtD     = bus.immExtD;
    assign bus4.rs1D        = bus.rs1D;
    assign bus4.rs2D        = bus.rs2D;
    assign bus4.rdD         = bus.rdD;
    assign bus4.regWriteD   = bus.regWriteD;
    assign bus4.aluSrcD     = bus.aluSrcD;
    assign bus4.memWriteD   = bus.memWriteD;
    assign bus4.resultSrcD  = bus.resultSrcD;
    assign bus4.branchD     = bus.branchD;
    assign bus4.aluControlD = bus.aluControlD;
    assign bus4.flushE      = bus.flushE;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic rw,
                         input logic rs, input logic mw, input logic [2:0] alu);
        bus.validD      = v;
        bus.pcD         = pc;
        bus.pcPlus4D    = pc + 32'd4;
        bus.rd1D        = 32'hA000_0000 | pc;
        bus.rd2D        = 32'hB000_0000 | pc;
        bus.immExtD     = 32'h0000_0010;
        bus.rs1D        = rs1;
        bus.rs2D        = rs2;
        bus.rdD         = rd;
        bus.regWriteD   = rw;
        bus.aluSrcD     = 1'b0;
        bus.memWriteD   = mw;
        bus.resultSrcD  = rs;
        bus.branchD     = 1'b0;
        bus.aluControlD = alu;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.flushE = 1'b0;
        drive(1'b1, $urandom, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, 1'b1, 3'($urandom));
        tick();
        drive(1'b1, $urandom, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, 1'b1, 3'($urandom));
        tick();
        n_tests++;
        if (bus.validE !== 1'b0 || bus.pcE !== 32'd0 || bus.rdE !== 5'd0 || bus.rd1E !== 32'd0) begin
            $display("FAIL reset_regs validE=%b pcE=%h rdE=%0d rd1E=%h want 0", bus.validE, bus.pcE, bus.rdE, bus.rd1E);
            n_fail++;
        end
        n_tests++;
        if ({bus.regWriteE, bus.memWriteE, bus.resultSrcE, bus.branchE, bus.aluSrcE, bus.aluControlE} !== 8'd0) begin
            $display("FAIL reset_ctrl got %b want 0", {bus.regWriteE, bus.memWriteE, bus.resultSrcE, bus.branchE, bus.aluSrcE, bus.aluControlE});
            n_fail++;
        end
        n_tests++;
        if (bus.stallF !== 1'b0 || bus.stallD !== 1'b0 || bus.bubbleCount !== 16'd0 || bus4.bubbleCount !== 4'd0) begin
            $display("FAIL reset_stall_cnt stallF=%b stallD=%b cnt=%0d cnt4=%0d want 0", bus.stallF, bus.stallD, bus.bubbleCount, bus4.bubbleCount);
            n_fail++;
        end
        rst = 1'b0;
    endtask

    task automatic test_pass_through();
        drive(1'b1, 32'h100, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 3'b010);
        tick();
        n_tests++;
        if (bus.pcE !== 32'h100 || bus.aluControlE !== 3'd2 || bus.regWriteE !== 1'b1 || bus.rdE !== 5'd5 || bus.validE !== 1'b1) begin
            $display("FAIL pass_through pcE=%h alu=%0d rw=%b rdE=%0d validE=%b want 100/2/1/5/1", bus.pcE, bus.aluControlE, bus.regWriteE, bus.rdE, bus.validE);
            n_fail++;
        end
        n_tests++;
        if (bus.pcPlus4E !== 32'h104 || bus.rd1E !== 32'hA000_0100 || bus.rd2E !== 32'hB000_0100 || bus.immExtE !== 32'h10 || bus.rs1E !== 5'd1 || bus.rs2E !== 5'd2) begin
            $display("FAIL pass_data pc4=%h rd1=%h rd2=%h imm=%h rs1=%0d rs2=%0d", bus.pcPlus4E, bus.rd1E, bus.rd2E, bus.immExtE, bus.rs1E, bus.rs2E);
            n_fail++;
        end
    endtask

    task automatic test_invalid_capture();
        drive(1'b0, 32'h200, 5'd3, 5'd4, 5'd6, 1'b1, 1'b1, 1'b1, 3'b111);
        bus.branchD = 1'b1;
        tick();
        n_tests++;
        if (bus.validE !== 1'b0 || bus.regWriteE !== 1'b0 || bus.memWriteE !== 1'b0 || bus.branchE !== 1'b0 || bus.aluControlE !== 3'd0 || bus.pcE !== 32'h200) begin
            $display("FAIL invalid_gate validE=%b rw=%b mw=%b br=%b alu=%0d pcE=%h want 0/0/0/0/0/200", bus.validE, bus.regWriteE, bus.memWriteE, bus.branchE, bus.aluControlE, bus.pcE);
            n_fail++;
        end
    endtask

    task automatic test_load_use();
        drive(1'b1, 32'h300, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 3'b000);
        tick();
        drive(1'b1, 32'h304, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b0, 3'b000);
        n_tests++;
        if (bus.stallF !== 1'b1 || bus.stallD !== 1'b1) begin
            $display("FAIL load_use_stall stallF=%b stallD=%b want 1", bus.stallF, bus.stallD);
            n_fail++;
        end
        tick();
        n_tests++;
        if (bus.validE !== 1'b0 || bus.regWriteE !== 1'b0 || bus.resultSrcE !== 1'b0 || bus.bubbleCount !== 16'd1 || bus4.bubbleCount !== 4'd1) begin
            $display("FAIL load_use_bubble validE=%b rw=%b rs=%b cnt=%0d cnt4=%0d want 0/0/0/1/1", bus.validE, bus.regWriteE, bus.resultSrcE, bus.bubbleCount, bus4.bubbleCount);
            n_fail++;
        end
        n_tests++;
        if (bus.stallD !== 1'b0) begin
            $display("FAIL load_use_single stallD=%b want 0", bus.stallD);
            n_fail++;
        end
        tick();
        n_tests++;
        if (bus.validE !== 1'b1 || bus.pcE !== 32'h304 || bus.rs1E !== 5'd5 || bus.rdE !== 5'd7 || bus.bubbleCount !== 16'd1) begin
            $display("FAIL load_use_resume validE=%b pcE=%h rs1E=%0d rdE=%0d cnt=%0d want 1/304/5/7/1", bus.validE, bus.pcE, bus.rs1E, bus.rdE, bus.bubbleCount);
            n_fail++;
        end
        drive(1'b1, 32'h308, 5'd1, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0, 3'b000);
        n_tests++;
        if (bus.stallF !== 1'b0) begin
            $display("FAIL alu_dep_no_stall stallF=%b want 0", bus.stallF);
            n_fail++;
        end
        drive(1'b1, 32'h30C, 5'd1, 5'd1, 5'd9, 1'b1, 1'b1, 1'b0, 3'b000);
        tick();
        drive(1'b1, 32'h310, 5'd3, 5'd9, 5'd4, 1'b0, 1'b0, 1'b1, 3'b000);
        n_tests++;
        if (bus.stallD !== 1'b1) begin
            $display("FAIL load_use_rs2 stallD=%b want 1", bus.stallD);
            n_fail++;
        end
        tick();
        tick();
        n_tests++;
        if (bus.validE !== 1'b1 || bus.memWriteE !== 1'b1 || bus.bubbleCount !== 16'd2) begin
            $display("FAIL rs2_resume validE=%b mw=%b cnt=%0d want 1/1/2", bus.validE, bus.memWriteE, bus.bubbleCount);
            n_fail++;
        end
    endtask

    task automatic test_x0_load();
        drive(1'b1, 32'h400, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 3'b000);
        tick();
        drive(1'b1, 32'h404, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 3'b001);
        n_tests++;
        if (bus.stallF !== 1'b0 || bus.stallD !== 1'b0) begin
            $display("FAIL x0_no_stall stallF=%b stallD=%b want 0", bus.stallF, bus.stallD);
            n_fail++;
        end
        tick();
        n_tests++;
        if (bus.validE !== 1'b1 || bus.pcE !== 32'h404 || bus.aluControlE !== 3'd1 || bus.bubbleCount !== 16'd2) begin
            $display("FAIL x0_capture validE=%b pcE=%h alu=%0d cnt=%0d want 1/404/1/2", bus.validE, bus.pcE, bus.aluControlE, bus.bubbleCount);
            n_fail++;
        end
    endtask

    task automatic test_flush_priority();
        drive(1'b1, 32'h500, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 3'b000);
        tick();
        drive(1'b1, 32'h504, 5'd5, 5'd6, 5'd0, 1'b0, 1'b0, 1'b1, 3'b000);
        bus.flushE = 1'b1;
        #1;
        n_tests++;
        if (bus.stallF !== 1'b0 || bus.stallD !== 1'b0) begin
            $display("FAIL flush_no_stall stallF=%b stallD=%b want 0", bus.stallF, bus.stallD);
            n_fail++;
        end
        tick();
        n_tests++;
        if (bus.validE !== 1'b0 || bus.memWriteE !== 1'b0 || bus.pcE !== 32'd0 || bus.bubbleCount !== 16'd3 || bus4.bubbleCount !== 4'd3) begin
            $display("FAIL flush_bubble validE=%b mw=%b pcE=%h cnt=%0d cnt4=%0d want 0/0/0/3/3", bus.validE, bus.memWriteE, bus.pcE, bus.bubbleCount, bus4.bubbleCount);
            n_fail++;
        end
        bus.flushE = 1'b0;
    endtask

    task automatic test_saturation();
        drive(1'b1, 32'h600, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 3'b000);
        bus.flushE = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        bus.flushE = 1'b0;
        n_tests++;
        if (bus4.bubbleCount !== 4'hF || bus.bubbleCount !== 16'd23) begin
            $display("FAIL saturation cnt4=%0d cnt16=%0d want 15/23", bus4.bubbleCount, bus.bubbleCount);
            n_fail++;
        end
        tick();
        n_tests++;
        if (bus4.bubbleCount !== 4'hF || bus.validE !== 1'b1) begin
            $display("FAIL sat_hold cnt4=%0d validE=%b want 15/1", bus4.bubbleCount, bus.validE);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b1, 32'h700, 5'd1, 5'd2, 5'd10, 1'b1, 1'b1, 1'b0, 3'b000);
        tick();
        drive(1'b1, 32'h704, 5'd10, 5'd0, 5'd11, 1'b1, 1'b0, 1'b0, 3'b000);
        n_tests++;
        if (bus.stallF !== 1'b1) begin
            $display("FAIL pre_rst_stall stallF=%b want 1", bus.stallF);
            n_fail++;
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.stallF !== 1'b0 || bus.stallD !== 1'b0) begin
            $display("FAIL rst_stall_mask stallF=%b stallD=%b want 0", bus.stallF, bus.stallD);
            n_fail++;
        end
        tick();
        rst = 1'b0;
        #1;
        n_tests++;
        if (bus.validE !== 1'b0 || bus.bubbleCount !== 16'd0 || bus4.bubbleCount !== 4'd0 || bus.stallD !== 1'b0) begin
            $display("FAIL rst_mid_stall validE=%b cnt=%0d cnt4=%0d stallD=%b want 0/0/0/0", bus.validE, bus.bubbleCount, bus4.bubbleCount, bus.stallD);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_invalid_capture();
        test_load_use();
        test_x0_load();
        test_flush_priority();
        test_saturation();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
